// File: rtl/aes_round_sequencer_if.sv
// Handshake and control bundle between the AES block wrapper and the round sequencer.
// The master side is the wrapper; the slave side is the sequencer.
interface aes_round_sequencer_if;
   logic       start_valid;
   logic       start_ready;
   logic       abort;
   logic       state_load;
   logic       key_load;
   logic       round_en;
   logic       last_round;
   logic [3:0] round_idx;
   logic [7:0] rcon;
   logic       done_valid;
   logic       done_ready;

   modport master (
      output start_valid, abort, done_ready,
      input  start_ready, state_load, key_load, round_en, last_round, round_idx, rcon,
             done_valid
   );

   modport slave (
      input  start_valid, abort, done_ready,
      output start_ready, state_load, key_load, round_en, last_round, round_idx, rcon,
             done_valid
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES-128 round datapath: initial key load, NR rounds with
// round index / rcon / final-round bypass, and a done handshake. Holds no data.
module aes_round_sequencer #(
   parameter int unsigned NR           = 10,
   parameter int unsigned ROUND_CYCLES = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   aes_round_sequencer_if.slave  bus_io
);

   localparam int unsigned    CntW    = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ROUND_CYCLES - 1);
   localparam logic [3:0]     IdxLast = 4'(NR);

   typedef enum logic [1:0] {StIdle, StLoad, StRound, StDone} state_e;

   state_e          state_q, state_d;
   logic [3:0]      idx_q, idx_d;
   logic [7:0]      rcon_q, rcon_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic start_ready, state_load, key_load, round_en, last_round, done_valid;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         rcon_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rcon_q  <= rcon_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rcon_d      = rcon_q;
      cnt_d       = cnt_q;
      start_ready = 1'b0;
      state_load  = 1'b0;
      key_load    = 1'b0;
      round_en    = 1'b0;
      last_round  = 1'b0;
      done_valid  = 1'b0;

      unique case (state_q)
         StIdle: begin
            start_ready = !bus_io.abort;
            if (bus_io.start_valid && !bus_io.abort) state_d = StLoad;
         end
         StLoad: begin
            state_load = 1'b1;
            key_load   = 1'b1;
            if (bus_io.abort) begin
               state_d = StIdle;
            end else begin
               state_d = StRound;
               idx_d   = 4'd1;
               rcon_d  = 8'h01;
               cnt_d   = '0;
            end
         end
         StRound: begin
            last_round = (idx_q == IdxLast);
            if (bus_io.abort) begin
               state_d = StIdle;
            end else if (cnt_q == CntLast) begin
               // Abort takes priority, so round_en is only raised when the round really commits.
               round_en = 1'b1;
               if (idx_q == IdxLast) begin
                  state_d = StDone;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  rcon_d = xtime(rcon_q);
                  cnt_d  = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            done_valid = 1'b1;
            if (bus_io.abort || bus_io.done_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Every path back to idle clears the round bookkeeping.
      if (state_d == StIdle) begin
         idx_d  = '0;
         rcon_d = '0;
         cnt_d  = '0;
      end
   end

   assign bus_io.start_ready = start_ready;
   assign bus_io.state_load  = state_load;
   assign bus_io.key_load    = key_load;
   assign bus_io.round_en    = round_en;
   assign bus_io.last_round  = last_round;
   assign bus_io.round_idx   = idx_q;
   assign bus_io.rcon        = rcon_q;
   assign bus_io.done_valid  = done_valid;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: three configurations share one stimulus stream and are
// checked every cycle against a cycle-count model, plus literal latency/rcon expectations.
module tb_aes_round_sequencer;

   function automatic int nr_of(input int c);
      return (c == 2) ? 14 : 10;
   endfunction

   function automatic int rc_of(input int c);
      return (c == 1) ? 3 : 1;
   endfunction

   // Round constant as a power of x in GF(2^8), plain integer arithmetic.
   function automatic int rc_ref(input int k);
      int v = 1;
      for (int i = 1; i < k; i++) begin
         v = v * 2;
         if (v > 255) v = v ^ 'h11b;
      end
      return v;
   endfunction

   logic clk = 1'b0;
   logic rst_n, start_valid, abort, done_ready;
   int   cyc = 0;
   int   total = 0, bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       o_sr [3], o_sl [3], o_kl [3], o_re [3], o_lr [3], o_dv [3];
   logic [3:0] o_idx [3];
   logic [7:0] o_rc [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_round_sequencer_if u_if ();
      assign u_if.start_valid = start_valid;
      assign u_if.abort       = abort;
      assign u_if.done_ready  = done_ready;
      assign o_sr[g]  = u_if.start_ready;
      assign o_sl[g]  = u_if.state_load;
      assign o_kl[g]  = u_if.key_load;
      assign o_re[g]  = u_if.round_en;
      assign o_lr[g]  = u_if.last_round;
      assign o_dv[g]  = u_if.done_valid;
      assign o_idx[g] = u_if.round_idx;
      assign o_rc[g]  = u_if.rcon;
      aes_round_sequencer #(
         .NR          (nr_of(g)),
         .ROUND_CYCLES(rc_of(g))
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus_io(u_if)
      );
   end

   task automatic check(input string name, input int c, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s cfg%0d t=%0t got=%0h want=%0h", name, c, $time, got, exp);
      end
   endtask

   // Model: mode 0 idle, 1 busy (t = cycles since the load cycle), 2 done.
   int m_mode [3] = '{0, 0, 0};
   int m_t    [3] = '{0, 0, 0};
   int n_mode [3] = '{0, 0, 0};
   int n_t    [3] = '{0, 0, 0};

   always @(posedge clk or negedge rst_n) begin
      for (int c = 0; c < 3; c++) begin
         if (!rst_n) begin
            m_mode[c] = 0;
            m_t[c]    = 0;
         end else begin
            m_mode[c] = n_mode[c];
            m_t[c]    = n_t[c];
         end
      end
   end

   // Event log used by the literal checks.
   int  en_q [3][$];
   int  rcl_q [3][$];
   int  idx_q [3][$];
   int  lr_q [3][$];
   int  acc [3];
   int  done_rel [3];
   bit  dv_seen [3];

   always @(negedge clk) begin
      for (int c = 0; c < 3; c++) begin
         int nr, rcy, k;
         int e_sr, e_sl, e_re, e_lr, e_dv, e_idx, e_rc;
         nr = nr_of(c);
         rcy = rc_of(c);
         e_sr = 0; e_sl = 0; e_re = 0; e_lr = 0; e_dv = 0; e_idx = 0; e_rc = 0;
         case (m_mode[c])
            0: e_sr = int'(!abort);
            1: begin
               if (m_t[c] == 0) begin
                  e_sl = 1;
               end else begin
                  k     = (m_t[c] - 1) / rcy + 1;
                  e_idx = k;
                  e_rc  = rc_ref(k);
                  e_re  = int'((m_t[c] % rcy == 0) && !abort);
                  e_lr  = int'(k == nr);
               end
            end
            default: begin
               e_dv  = 1;
               e_idx = nr;
               e_rc  = rc_ref(nr);
            end
         endcase
         check("start_ready", c, int'(o_sr[c]), e_sr);
         check("state_load", c, int'(o_sl[c]), e_sl);
         check("key_load", c, int'(o_kl[c]), e_sl);
         check("round_en", c, int'(o_re[c]), e_re);
         check("last_round", c, int'(o_lr[c]), e_lr);
         check("done_valid", c, int'(o_dv[c]), e_dv);
         check("round_idx", c, int'(o_idx[c]), e_idx);
         check("rcon", c, int'(o_rc[c]), e_rc);

         n_mode[c] = m_mode[c];
         n_t[c]    = m_t[c];
         if (!rst_n) begin
            n_mode[c] = 0;
         end else if (m_mode[c] == 0) begin
            if (start_valid && !abort) begin
               n_mode[c] = 1;
               n_t[c]    = 0;
            end
         end else if (m_mode[c] == 1) begin
            if (abort) n_mode[c] = 0;
            else if (m_t[c] == nr * rcy) n_mode[c] = 2;
            else n_t[c] = m_t[c] + 1;
         end else if (abort || done_ready) begin
            n_mode[c] = 0;
         end

         if (rst_n) begin
            if (start_valid && o_sr[c]) acc[c] = cyc;
            if (o_re[c]) begin
               en_q[c].push_back(cyc - acc[c]);
               rcl_q[c].push_back(int'(o_rc[c]));
               idx_q[c].push_back(int'(o_idx[c]));
            end
            if (o_lr[c]) lr_q[c].push_back(cyc - acc[c]);
            if (o_dv[c] && !dv_seen[c]) begin
               dv_seen[c]  = 1'b1;
               done_rel[c] = cyc - acc[c];
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      for (int c = 0; c < 3; c++) begin
         en_q[c].delete();
         rcl_q[c].delete();
         idx_q[c].delete();
         lr_q[c].delete();
         done_rel[c] = -1;
         dv_seen[c]  = 1'b0;
      end
   endtask

   task automatic flush();
      start_valid = 1'b0;
      abort       = 1'b1;
      step(2);
      abort = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(o_sr[0] && o_sr[1] && o_sr[2]) && n < budget) begin
         step(1);
         n++;
      end
      check("wait_idle_timeout", 0, int'(n < budget), 1);
   endtask

   task automatic pulse_start();
      start_valid = 1'b1;
      step(1);
      start_valid = 1'b0;
   endtask

   logic [7:0] rc10 [10];
   logic [7:0] rc14 [4];

   initial begin
      rc10 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      rc14 = '{8'h6c, 8'hd8, 8'hab, 8'h4d};
      rst_n = 1'b0; start_valid = 1'b0; abort = 1'b0; done_ready = 1'b1;
      clear_log();
      step(2);
      check("reset_idx", 0, int'(o_idx[0]), 0);
      check("reset_rcon", 0, int'(o_rc[0]), 0);
      rst_n = 1'b1;
      step(1);

      // Full encryption on all three configurations at once.
      clear_log();
      pulse_start();
      wait_idle(60);
      check("en_count", 0, en_q[0].size(), 10);
      for (int i = 0; i < 10; i++) begin
         check("en_cycle", 0, en_q[0][i], i + 2);
         check("rcon_seq", 0, rcl_q[0][i], int'(rc10[i]));
         check("en_cycle", 1, en_q[1][i], 4 + 3 * i);
      end
      check("lr_count", 0, lr_q[0].size(), 1);
      check("lr_cycle", 0, lr_q[0][0], 11);
      check("done_cycle", 0, done_rel[0], 12);
      check("en_count", 1, en_q[1].size(), 10);
      check("done_cycle", 1, done_rel[1], 32);
      check("en_count", 2, en_q[2].size(), 14);
      for (int i = 0; i < 4; i++) check("rcon_tail", 2, rcl_q[2][10 + i], int'(rc14[i]));
      check("idx_max", 2, idx_q[2][13], 14);
      check("done_cycle", 2, done_rel[2], 16);

      // Consumer stalls; start requested meanwhile.
      clear_log();
      done_ready = 1'b0;
      pulse_start();
      for (int n = 0; n < 40 && !o_dv[0]; n++) step(1);
      check("dv_reached", 0, int'(o_dv[0]), 1);
      start_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         step(1);
         check("dv_held", 0, int'(o_dv[0]), 1);
         check("no_turnaround", 0, int'(o_sr[0]), 0);
         check("no_reload", 0, int'(o_sl[0]), 0);
      end
      done_ready = 1'b1;
      step(1);
      check("idle_after_ready", 0, int'(o_sr[0]), 1);
      step(1);
      check("restart_load", 0, int'(o_sl[0]), 1);
      start_valid = 1'b0;
      flush();

      // Abort on the round_en cycle of round 5.
      clear_log();
      pulse_start();
      for (int n = 0; n < 30 && o_idx[0] != 4'd5; n++) step(1);
      check("reach_round5", 0, int'(o_idx[0]), 5);
      abort = 1'b1;
      #1;
      check("abort_blocks_en", 0, int'(o_re[0]), 0);
      step(1);
      abort = 1'b0;
      #1;
      check("abort_idx", 0, int'(o_idx[0]), 0);
      check("abort_rcon", 0, int'(o_rc[0]), 0);
      check("abort_idle", 0, int'(o_sr[0]), 1);
      step(3);
      check("abort_no_done", 0, int'(dv_seen[0]), 0);
      clear_log();
      pulse_start();
      wait_idle(60);
      check("post_abort_rounds", 0, en_q[0].size(), 10);
      check("post_abort_done", 0, done_rel[0], 12);

      // Asynchronous reset between edges while rounds are running.
      clear_log();
      pulse_start();
      step(4);
      #2 rst_n = 1'b0;
      #1;
      check("arst_idx", 0, int'(o_idx[0]), 0);
      check("arst_rcon", 0, int'(o_rc[0]), 0);
      check("arst_en", 0, int'(o_re[0]), 0);
      check("arst_sr", 0, int'(o_sr[0]), 1);
      step(1);
      rst_n = 1'b1;
      step(1);
      check("post_reset_ready", 0, int'(o_sr[0]), 1);

      // Random traffic checked against the model every cycle.
      for (int n = 0; n < 3000; n++) begin
         start_valid = ($urandom % 4) == 0;
         abort       = ($urandom % 20) == 0;
         done_ready  = ($urandom % 2) == 0;
         if (($urandom % 700) == 0) begin
            #2 rst_n = 1'b0;
            step(1);
            rst_n = 1'b1;
         end else begin
            step(1);
         end
      end
      flush();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t got=running want=finished", $time);
      $fatal(1, "watchdog");
   end

endmodule
